mem_read_arbiter: RTL

- Egress counterpart of the ingress write/free-list/learn arbiter.
- Time-division multiplexes the shared packet-buffer read port among NUM_PORTS TX memory read controllers and routes each read response back to the port that issued it.
- Also arbitrates per-port block-release (free) requests into the single free-list return interface, using a one-entry holding register per port and round-robin selection.

---
 rtl/mem_read_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: shares one packet-buffer read port among NUM_PORTS TX read
// controllers by fixed time slots, steers each read response back to the port
// that issued it, and funnels per-port block releases into the single
// free-list return interface through one-entry holds and round-robin offers.
// Optional per-port read/free counters are built when MEM_READ_ARB_STATS_EN
// is defined.

// One-entry free holding register for a single port.
module mem_read_arbiter_hold #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic [ADDR_W-1:0] idx,
  input  logic              clr,
  output logic              gnt,
  output logic              hv,
  output logic [ADDR_W-1:0] hidx
);
  // A full hold refuses new requests, so a clear and a capture never collide.
  assign gnt = req & ~hv;

  // Capture on grant, release when the free list takes this entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv   <= 1'b0;
      hidx <= '0;
    end else if (gnt) begin
      hv   <= 1'b1;
      hidx <= idx;
    end else if (clr) begin
      hv   <= 1'b0;
    end
  end
endmodule

module mem_read_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int ADDR_W     = 10,
  parameter int BLOCK_BITS = 64,
  parameter int RD_LAT     = 1
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_PORTS-1:0]              mem_re_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  mem_raddr_i,
  output logic [NUM_PORTS-1:0]              mem_rgnt_o,
  output logic [NUM_PORTS-1:0]              mem_rvalid_o,
  output logic [BLOCK_BITS-1:0]             mem_rdata_o,
  output logic                              mem_re_o,
  output logic [ADDR_W-1:0]                 mem_raddr_o,
  input  logic [BLOCK_BITS-1:0]             mem_rdata_i,
  input  logic [NUM_PORTS-1:0]              fl_free_req_i,
  input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  fl_free_idx_i,
  output logic [NUM_PORTS-1:0]              fl_free_gnt_o,
  output logic                              fl_free_req_o,
  output logic [ADDR_W-1:0]                 fl_free_idx_o,
  input  logic                              fl_free_gnt_i
`ifdef MEM_READ_ARB_STATS_EN
  ,
  output logic [NUM_PORTS-1:0][31:0]        rd_cnt_o,
  output logic [NUM_PORTS-1:0][31:0]        free_cnt_o
`endif
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam logic [PW-1:0] LAST = PW'(NUM_PORTS - 1);
  localparam logic IDLE  = 1'b0;
  localparam logic OFFER = 1'b1;

  logic [PW-1:0] cur;

  // Slot counter; explicit wrap so non-power-of-2 port counts work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cur <= '0;
    else        cur <= (cur == LAST) ? '0 : cur + 1'b1;
  end

  assign mem_re_o    = mem_re_i[cur];
  assign mem_raddr_o = mem_raddr_i[cur];
  assign mem_rdata_o = mem_rdata_i;

  // Only the slot owner can be granted.
  always_comb begin
    mem_rgnt_o      = '0;
    mem_rgnt_o[cur] = mem_re_i[cur];
  end

  // Response tags travel alongside the memory latency.
  logic [RD_LAT-1:0]         vld_pipe;
  logic [RD_LAT-1:0][PW-1:0] port_pipe;

  // Tag shift register: {valid, port} per stage; reset drops in-flight tags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      port_pipe <= '0;
    end else begin
      vld_pipe[0]  <= mem_re_o;
      port_pipe[0] <= cur;
      for (int s = 1; s < RD_LAT; s++) begin
        vld_pipe[s]  <= vld_pipe[s-1];
        port_pipe[s] <= port_pipe[s-1];
      end
    end
  end

  // Decode the last-stage tag into a one-hot valid.
  always_comb begin
    mem_rvalid_o = '0;
    mem_rvalid_o[port_pipe[RD_LAT-1]] = vld_pipe[RD_LAT-1];
  end

  // Free path: per-port holds feeding a two-state offer machine.
  logic                             state;
  logic [PW-1:0]                    sel;
  logic [PW-1:0]                    rr_ptr;
  logic [NUM_PORTS-1:0]             hold_v;
  logic [NUM_PORTS-1:0][ADDR_W-1:0] hold_idx;
  logic [NUM_PORTS-1:0]             clr;
  logic [PW-1:0]                    pick;
  logic                             found;
  int                               p;

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_hold
    assign clr[g] = (state == OFFER) && fl_free_gnt_i && (sel == PW'(g));
    mem_read_arbiter_hold #(.ADDR_W(ADDR_W)) u_hold (
      .clk  (clk),
      .rst_n(rst_n),
      .req  (fl_free_req_i[g]),
      .idx  (fl_free_idx_i[g]),
      .clr  (clr[g]),
      .gnt  (fl_free_gnt_o[g]),
      .hv   (hold_v[g]),
      .hidx (hold_idx[g])
    );
  end

  // First full hold at or after rr_ptr, wrapping.
  always_comb begin
    pick  = '0;
    found = 1'b0;
    p     = 0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      p = int'(rr_ptr) + k;
      if (p >= NUM_PORTS) p = p - NUM_PORTS;
      if (!found && hold_v[p]) begin
        pick  = PW'(p);
        found = 1'b1;
      end
    end
  end

  // Offer FSM: sel is locked for the whole offer so late arrivals wait.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      sel    <= '0;
      rr_ptr <= '0;
    end else begin
      case (state)
        IDLE: if (|hold_v) begin
          sel   <= pick;
          state <= OFFER;
        end
        default: if (fl_free_gnt_i) begin
          rr_ptr <= (sel == LAST) ? '0 : sel + 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  assign fl_free_req_o = (state == OFFER);
  assign fl_free_idx_o = fl_free_req_o ? hold_idx[sel] : '0;

`ifdef MEM_READ_ARB_STATS_EN
  // Per-port activity counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_o   <= '0;
      free_cnt_o <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (mem_rgnt_o[i]) rd_cnt_o[i]   <= rd_cnt_o[i] + 32'd1;
        if (clr[i])        free_cnt_o[i] <= free_cnt_o[i] + 32'd1;
      end
    end
  end
`endif
endmodule
